// File: rtl/control_subcmd_fillrect_pkg.sv
// Shared types and constants for the fill-rectangle control subcommand.
// Panel geometry defaults, address/lane widths, fill modes and the clip helper.
package control_subcmd_fillrect_pkg;

    localparam int DEF_BYTES_PER_PIXEL  = 2;
    localparam int DEF_PIXEL_WIDTH      = 64;
    localparam int DEF_PIXEL_HEIGHT     = 32;
    localparam int DEF_PIXEL_HALFHEIGHT = 16;

    // Address types must also hold the full panel extent, since width/height use them
    localparam int COL_ADDR_BITS             = $clog2(DEF_PIXEL_WIDTH + 1);
    localparam int ROW_ADDR_BITS             = $clog2(2 * DEF_PIXEL_HALFHEIGHT + 1);
    localparam int NUM_PIXELCOLORSELECT_BITS = (DEF_BYTES_PER_PIXEL > 1) ? $clog2(DEF_BYTES_PER_PIXEL) : 1;
    localparam int NUM_DATA_A_BITS           = 8;
    localparam int COLOR_BITS                = DEF_BYTES_PER_PIXEL * NUM_DATA_A_BITS;

    typedef logic [31:0]                          uint_t;
    typedef logic [COL_ADDR_BITS-1:0]             col_addr_t;
    typedef logic [ROW_ADDR_BITS-1:0]             row_addr_t;
    typedef logic [NUM_PIXELCOLORSELECT_BITS-1:0] pixel_sel_t;
    typedef logic [NUM_DATA_A_BITS-1:0]           data_t;
    typedef logic [COLOR_BITS-1:0]                color_t;

    typedef enum logic [1:0] {
        FILL_SOLID     = 2'd0,
        FILL_OUTLINE   = 2'd1,
        FILL_CHECKER   = 2'd2,
        FILL_SOLID_ALT = 2'd3
    } fill_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last covered index of a span, clipped to the panel; caller guarantees len >= 1
    function automatic uint_t clip_end(input uint_t start, input uint_t len, input uint_t limit);
        uint_t last;
        last = start + len - 32'd1;
        return (last > limit - 32'd1) ? (limit - 32'd1) : last;
    endfunction

endpackage

// File: rtl/control_subcmd_fillrect_bounds.sv
// Combinational clip of a rectangle against the panel: inclusive end
// coordinates plus an empty flag for zero-size or fully off-panel rectangles.
module fillrect_bounds
    import control_subcmd_fillrect_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT = DEF_PIXEL_HEIGHT
) (
    input  col_addr_t x1_i,
    input  row_addr_t y1_i,
    input  col_addr_t width_i,
    input  row_addr_t height_i,
    output col_addr_t x_end_o,
    output row_addr_t y_end_o,
    output logic      empty_o
);

    uint_t x_end_u;
    uint_t y_end_u;

    assign x_end_u = clip_end(uint_t'(x1_i), uint_t'(width_i), uint_t'(PIXEL_WIDTH));
    assign y_end_u = clip_end(uint_t'(y1_i), uint_t'(height_i), uint_t'(PIXEL_HEIGHT));

    assign x_end_o = col_addr_t'(x_end_u);
    assign y_end_o = row_addr_t'(y_end_u);

    assign empty_o = (width_i == '0) || (height_i == '0)
                  || (uint_t'(x1_i) >= uint_t'(PIXEL_WIDTH))
                  || (uint_t'(y1_i) >= uint_t'(PIXEL_HEIGHT));

endmodule

// File: rtl/control_subcmd_fillrect.sv
// Rectangle writer: solid, outline or checker fill into panel RAM, one byte per clock.
// Define FILLRECT_PATTERN_EN to enable checker mode and the color2 input.
module control_subcmd_fillrect
    import control_subcmd_fillrect_pkg::*;
#(
    parameter int BYTES_PER_PIXEL  = DEF_BYTES_PER_PIXEL,
    parameter int PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT     = DEF_PIXEL_HEIGHT,
    parameter int PIXEL_HALFHEIGHT = DEF_PIXEL_HALFHEIGHT,
    parameter int _UNUSED          = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ack,
    input  fill_mode_t mode,
    input  col_addr_t  x1,
    input  row_addr_t  y1,
    input  col_addr_t  width,
    input  row_addr_t  height,
    input  color_t     color,
    input  color_t     color2,
    output row_addr_t  row,
    output col_addr_t  column,
    output pixel_sel_t pixel,
    output data_t      data_out,
    output logic       ram_write_enable,
    output logic       ram_access_start,
    output logic       done
);

    localparam pixel_sel_t PIX_LAST = pixel_sel_t'(BYTES_PER_PIXEL - 1);

    state_t     state_q, state_d;
    logic       enable_q;
    logic       load_cmd;
    col_addr_t  x1_q, width_q, x_end_q, x_end_d, col_q, col_d;
    row_addr_t  y1_q, height_q, y_end_q, y_end_d, row_q, row_d;
    fill_mode_t mode_q;
    color_t     color_q;
    pixel_sel_t pix_q, pix_d;
    data_t      data_q, data_d;
    logic       we_q, we_d, start_q, start_d, done_q, done_d;

    col_addr_t  b_x_end;
    row_addr_t  b_y_end;
    logic       b_empty;
    color_t     sel_color;
    logic       interior_row;

    logic [31:0] unused_params;
    assign unused_params = 32'(PIXEL_HALFHEIGHT + _UNUSED);

    fillrect_bounds #(
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .PIXEL_HEIGHT (PIXEL_HEIGHT)
    ) u_bounds (
        .x1_i     (x1_q),
        .y1_i     (y1_q),
        .width_i  (width_q),
        .height_i (height_q),
        .x_end_o  (b_x_end),
        .y_end_o  (b_y_end),
        .empty_o  (b_empty)
    );

    assign interior_row = (row_q != y_end_q) && (row_q != y1_q);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        pix_d    = pix_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        we_d     = 1'b0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        load_cmd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !enable_q) begin
                    state_d  = ST_SETUP;
                    load_cmd = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (b_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    x_end_d = b_x_end;
                    y_end_d = b_y_end;
                    row_d   = b_y_end;
                    col_d   = b_x_end;
                    pix_d   = PIX_LAST;
                    we_d    = 1'b1;
                    start_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d  = 1'b1;
                    pix_d = PIX_LAST;
                    if (pix_q != '0) begin
                        pix_d = pix_q - pixel_sel_t'(1);
                    end else if (mode_q == FILL_OUTLINE && interior_row
                                 && col_q == x_end_q && x_end_q != x1_q) begin
                        // Outline interior row: right edge done, skip straight to the left edge
                        col_d = x1_q;
                    end else if (col_q != x1_q) begin
                        col_d = col_q - col_addr_t'(1);
                    end else if (row_q != y1_q) begin
                        row_d = row_q - row_addr_t'(1);
                        col_d = x_end_q;
                    end else begin
                        we_d    = 1'b0;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FILLRECT_PATTERN_EN
    color_t color2_q;
    // Colour follows the parity of the address about to be written
    assign sel_color = (mode_q == FILL_CHECKER && (row_d[0] ^ col_d[0])) ? color2_q : color_q;
`else
    logic unused_color2;
    assign unused_color2 = ^color2;
    assign sel_color     = color_q;
`endif

    data_t lane [BYTES_PER_PIXEL];
    for (genvar gi = 0; gi < BYTES_PER_PIXEL; gi++) begin : g_lane
        assign lane[gi] = sel_color[gi*NUM_DATA_A_BITS +: NUM_DATA_A_BITS];
    end

    assign data_d = we_d ? lane[pix_d] : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            x1_q     <= '0;
            y1_q     <= '0;
            width_q  <= '0;
            height_q <= '0;
            mode_q   <= FILL_SOLID;
            color_q  <= '0;
`ifdef FILLRECT_PATTERN_EN
            color2_q <= '0;
`endif
            x_end_q  <= '0;
            y_end_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pix_q    <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            if (load_cmd) begin
                x1_q     <= x1;
                y1_q     <= y1;
                width_q  <= width;
                height_q <= height;
                mode_q   <= mode;
                color_q  <= color;
`ifdef FILLRECT_PATTERN_EN
                color2_q <= color2;
`endif
            end
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pix_q    <= pix_d;
            data_q   <= data_d;
            we_q     <= we_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign row              = row_q;
    assign column           = col_q;
    assign pixel            = pix_q;
    assign data_out         = data_q;
    assign ram_write_enable = we_q;
    assign ram_access_start = start_q;
    assign done             = done_q;

endmodule

// File: tb/tb_control_subcmd_fillrect.sv
// Bench for control_subcmd_fillrect: table of directed rectangles, random rectangles
// against a per-pixel reference model, plus abort and mid-write reset sequences.
module tb_control_subcmd_fillrect;
    import control_subcmd_fillrect_pkg::*;

    localparam int BPP = DEF_BYTES_PER_PIXEL;
    localparam int PW  = DEF_PIXEL_WIDTH;
    localparam int PH  = DEF_PIXEL_HEIGHT;
`ifdef FILLRECT_PATTERN_EN
    localparam bit PATTERN_EN = 1'b1;
`else
    localparam bit PATTERN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, ack;
    fill_mode_t mode;
    col_addr_t  x1, width;
    row_addr_t  y1, height;
    color_t     color, color2;
    row_addr_t  row;
    col_addr_t  column;
    pixel_sel_t pixel;
    data_t      data_out;
    logic       ram_write_enable, ram_access_start, done;

    control_subcmd_fillrect dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .ack              (ack),
        .mode             (mode),
        .x1               (x1),
        .y1               (y1),
        .width            (width),
        .height           (height),
        .color            (color),
        .color2           (color2),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_out         (data_out),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .done             (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int r;
        int c;
        int p;
        int d;
    } wr_t;
    wr_t exp_q[$];

    // Every byte of every covered pixel, in raster order from bottom-right
    task automatic build_model(input int x1v, input int y1v, input int wv, input int hv,
                               input int md, input color_t c1, input color_t c2);
        int xe, ye;
        bit on_edge;
        color_t pc;
        exp_q.delete();
        if (wv == 0 || hv == 0 || x1v >= PW || y1v >= PH) return;
        xe = (x1v + wv - 1 < PW) ? x1v + wv - 1 : PW - 1;
        ye = (y1v + hv - 1 < PH) ? y1v + hv - 1 : PH - 1;
        for (int r = ye; r >= y1v; r--) begin
            for (int c = xe; c >= x1v; c--) begin
                on_edge = (r == ye) || (r == y1v) || (c == xe) || (c == x1v);
                if (md == 1 && !on_edge) continue;
                pc = (PATTERN_EN && md == 2 && ((r + c) % 2) == 1) ? c2 : c1;
                for (int p = BPP - 1; p >= 0; p--)
                    exp_q.push_back('{r, c, p, int'(pc[p*8 +: 8])});
            end
        end
    endtask

    task automatic run_cmd(input string name, input int x1v, input int y1v, input int wv,
                           input int hv, input int md, input color_t c1, input color_t c2,
                           input bit ack_glitch, output int nw);
        int  nexp;
        bit  got_done;
        wr_t e;
        got_done = 1'b0;
        nw = 0;
        build_model(x1v, y1v, wv, hv, md, c1, c2);
        nexp = exp_q.size();
        @(negedge clk);
        x1     = col_addr_t'(x1v);
        y1     = row_addr_t'(y1v);
        width  = col_addr_t'(wv);
        height = row_addr_t'(hv);
        mode   = fill_mode_t'(md[1:0]);
        color  = c1;
        color2 = c2;
        enable = 1'b1;
        @(negedge clk);
        chk({name, "/setup_quiet"}, {ram_write_enable, done}, 2'b00);
        for (int cyc = 0; cyc < nexp + 8 && !got_done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                if (nexp == 0) chk({name, "/empty_done"}, {ram_write_enable, done}, 2'b01);
                else           chk({name, "/first_write"}, {ram_write_enable, ram_access_start}, 2'b11);
            end
            ack = ack_glitch && (cyc == 0) && (nexp > 0);
            if (ram_write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/extra_write: got row %0d col %0d pix %0d, expected no write",
                             name, row, column, pixel);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s/write%0d", name, nw),
                        {ram_access_start, row, column, pixel, data_out},
                        {(cyc == 0), row_addr_t'(e.r), col_addr_t'(e.c), pixel_sel_t'(e.p), data_t'(e.d)});
                end
                nw++;
            end
            if (done) begin
                got_done = 1'b1;
                chk({name, "/done_cycle"}, cyc, nexp);
                chk({name, "/done_no_write"}, ram_write_enable, 1'b0);
            end
        end
        ack = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s/done_timeout: got no done, expected done after %0d writes", name, nexp);
        end
        chk({name, "/write_count"}, nw, nexp);
        @(negedge clk);
        chk({name, "/done_hold"}, {done, ram_write_enable}, 2'b10);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({name, "/ack_idle"}, {done, dut.state_q}, 0);
        repeat (2) begin
            @(negedge clk);
            chk({name, "/no_retrigger"}, {ram_write_enable, done}, 2'b00);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        string  name;
        int     x1, y1, w, h, md;
        color_t c1, c2;
        int     exp_n;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int nw, cnt, extra;
        vecs[0] = '{"solid_full",      0,  0, 64, 32, 0, 16'hA5A5, 16'h0000, 4096};
        vecs[1] = '{"clip",           60, 30, 10, 10, 0, 16'h3C5A, 16'h0000,   16};
        vecs[2] = '{"outline",         2,  3,  4,  3, 1, 16'h7E81, 16'h0000,   20};
        vecs[3] = '{"checker",         0,  0,  2,  2, 2, 16'h1234, 16'hABCD,    8};
        vecs[4] = '{"width_zero",      5,  5,  0,  4, 0, 16'hFFFF, 16'h0000,    0};
        vecs[5] = '{"mode3_solid",    10, 10,  3,  2, 3, 16'hBEEF, 16'h1111,   12};
        vecs[6] = '{"outline_1row",    1,  1,  5,  1, 1, 16'hC0DE, 16'h0000,   10};
        vecs[7] = '{"outline_clip",   61, 29,  8,  8, 1, 16'h0F0F, 16'h0000,   16};
        vecs[8] = '{"x_off_panel",    64,  0,  4,  4, 0, 16'h1357, 16'h0000,    0};
        vecs[9] = '{"y_off_panel",     0, 32,  4,  4, 0, 16'h2468, 16'h0000,    0};

        reset  = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        mode   = FILL_SOLID;
        x1     = '0;
        y1     = '0;
        width  = '0;
        height = '0;
        color  = '0;
        color2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, 0);
        chk("reset_state", dut.state_q, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].name, vecs[i].x1, vecs[i].y1, vecs[i].w, vecs[i].h, vecs[i].md,
                    vecs[i].c1, vecs[i].c2, 1'b0, nw);
            chk({vecs[i].name, "/table_count"}, nw, vecs[i].exp_n);
        end

        for (int i = 0; i < 25; i++) begin
            run_cmd($sformatf("rand%0d", i), int'($urandom_range(0, 68)), int'($urandom_range(0, 34)),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    color_t'($urandom), color_t'($urandom), 1'($urandom_range(0, 1)), nw);
        end

        // Abort after ten writes
        @(negedge clk);
        x1 = '0; y1 = '0; width = 8; height = 8; mode = FILL_SOLID; color = 16'h5A3C;
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 10; i++) begin
            @(negedge clk);
            if (ram_write_enable) cnt++;
        end
        enable = 1'b0;
        chk("abort/writes_seen", cnt, 10);
        @(negedge clk);
        chk("abort/idle", {ram_write_enable, done, dut.state_q}, 0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ram_write_enable || done) extra++;
        end
        chk("abort/quiet", extra, 0);

        // Reset in the middle of the write phase
        @(negedge clk);
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 5; i++) begin
            @(negedge clk);
            if (ram_write_enable) cnt++;
        end
        chk("reset_mid/writes_seen", cnt, 5);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("reset_mid/outputs", {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, 0);
        chk("reset_mid/state", dut.state_q, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid/idle_after", {ram_write_enable, done}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
